// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet path.
package usb_rx_pkg;

   localparam int unsigned RUN_W     = 3;
   localparam int unsigned STUFF_RUN = 6;

   // LSB is the oldest bit on the wire: seven zeros then the trailing one.
   localparam logic [7:0] SYNC_PATTERN = 8'b1000_0000;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DATA     = 2'd1,
      EOP_CHK  = 2'd2,
      WAIT_EOP = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_STUFF  = 2'd1,
      ERR_ALIGN  = 2'd2,
      ERR_BABBLE = 2'd3
   } rx_err_t;

endpackage

// File: rtl/usb_rx_packet_ctrl_unstuffer.sv
// Bit unstuffer: drops the bit following six consecutive ones; one-cycle latency.
module bit_unstuffer
   import usb_rx_pkg::*;
(
   input  logic             clk,
   input  logic             nRST,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             out_bit,
   output logic             out_valid,
   output logic [RUN_W-1:0] one_count
);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         out_bit   <= 1'b0;
         out_valid <= 1'b0;
         one_count <= '0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            // The bit after a full run is the stuffed bit; legality is judged upstream.
            if (one_count == RUN_W'(STUFF_RUN)) begin
               one_count <= '0;
            end else begin
               out_valid <= 1'b1;
               out_bit   <= in_bit;
               one_count <= in_bit ? one_count + RUN_W'(1) : '0;
            end
         end
      end
   end

endmodule

// File: rtl/usb_rx_packet_ctrl.sv
// Receive packet sequencer: SYNC hunt, unstuffing, byte assembly and packet framing.
module usb_rx_packet_ctrl
   import usb_rx_pkg::*;
#(
   parameter  int unsigned MAX_BYTES = 1027,
   localparam int unsigned COUNT_W   = $clog2(MAX_BYTES + 1)
)(
   input  logic               clk,
   input  logic               nRST,
   input  logic               rx_bit,
   input  logic               rx_se0,
   input  logic               rx_valid,
   output logic [7:0]         rx_byte,
   output logic               rx_byte_valid,
   output logic               rx_pkt_start,
   output logic               rx_pkt_end,
   output logic               rx_pkt_err,
   output logic [1:0]         rx_err_code,
   output logic               rx_active,
   output logic [COUNT_W-1:0] rx_byte_count
);

   rx_state_t        state;
   logic [7:0]       sync_sr;
   logic [7:0]       byte_sr;
   logic [2:0]       bit_cnt;
   logic             tag_q;
   logic             us_bit;
   logic             us_valid;
   logic [RUN_W-1:0] one_count;

   logic       se0_c;
   logic       fwd_c;
   logic       accept_c;
   logic       stuff_err_c;
   logic       babble_c;
   logic       assemble_c;
   logic [7:0] sync_next_c;
   logic [7:0] byte_next_c;

   bit_unstuffer u_unstuff (
      .clk       (clk),
      .nRST      (nRST),
      .in_bit    (rx_bit),
      .in_valid  (fwd_c),
      .out_bit   (us_bit),
      .out_valid (us_valid),
      .one_count (one_count)
   );

   // Per-cycle event decode; SE0 outranks stuff and babble checks.
   always_comb begin
      se0_c       = rx_valid & rx_se0;
      fwd_c       = rx_valid & ~rx_se0 & ((state == IDLE) | (state == DATA));
      accept_c    = us_valid & tag_q & (state == DATA);
      stuff_err_c = fwd_c & (state == DATA) & (one_count == RUN_W'(STUFF_RUN)) & rx_bit;
      babble_c    = accept_c & ~se0_c & (rx_byte_count == COUNT_W'(MAX_BYTES));
      assemble_c  = accept_c & ~babble_c;
      sync_next_c = {rx_bit, sync_sr[7:1]};
      byte_next_c = byte_sr;
      byte_next_c[bit_cnt] = us_bit;
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state         <= IDLE;
         sync_sr       <= 8'hFF;
         byte_sr       <= '0;
         bit_cnt       <= '0;
         tag_q         <= 1'b0;
         rx_byte       <= '0;
         rx_byte_valid <= 1'b0;
         rx_pkt_start  <= 1'b0;
         rx_pkt_end    <= 1'b0;
         rx_pkt_err    <= 1'b0;
         rx_err_code   <= ERR_NONE;
         rx_active     <= 1'b0;
         rx_byte_count <= '0;
      end else begin
         rx_byte_valid <= 1'b0;
         rx_pkt_start  <= 1'b0;
         rx_pkt_end    <= 1'b0;
         rx_pkt_err    <= 1'b0;
         // Only bits issued in DATA may reach the byte register; the SYNC tail is dropped.
         tag_q         <= fwd_c & (state == DATA);

         if (assemble_c) begin
            byte_sr <= byte_next_c;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte       <= byte_next_c;
               rx_byte_valid <= 1'b1;
               rx_byte_count <= rx_byte_count + COUNT_W'(1);
            end
         end

         case (state)
            IDLE: begin
               if (se0_c) begin
                  sync_sr <= 8'hFF;
               end else if (fwd_c) begin
                  sync_sr <= sync_next_c;
                  if (sync_next_c == SYNC_PATTERN) begin
                     state         <= DATA;
                     rx_pkt_start  <= 1'b1;
                     rx_active     <= 1'b1;
                     rx_byte_count <= '0;
                     rx_err_code   <= ERR_NONE;
                     bit_cnt       <= '0;
                  end
               end
            end
            DATA: begin
               if (se0_c) begin
                  state <= EOP_CHK;
               end else if (babble_c) begin
                  state       <= WAIT_EOP;
                  rx_pkt_err  <= 1'b1;
                  rx_err_code <= ERR_BABBLE;
               end else if (stuff_err_c) begin
                  state       <= WAIT_EOP;
                  rx_pkt_err  <= 1'b1;
                  rx_err_code <= ERR_STUFF;
               end
            end
            EOP_CHK: begin
               if ((bit_cnt == 3'd0) && (rx_byte_count != '0)) begin
                  rx_pkt_end <= 1'b1;
               end else begin
                  rx_pkt_err  <= 1'b1;
                  rx_err_code <= ERR_ALIGN;
               end
               state     <= IDLE;
               rx_active <= 1'b0;
               sync_sr   <= 8'hFF;
            end
            WAIT_EOP: begin
               if (se0_c) begin
                  state     <= IDLE;
                  rx_active <= 1'b0;
                  sync_sr   <= 8'hFF;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
